// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the HI/LO register pair: fixed-latency multiply,
// 32-step restoring divide, MTHI/MTLO moves, and one-cycle write-back strobes.
module mdu_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic        hi_we,
   output logic        lo_we,
   output logic [31:0] hi_wd,
   output logic [31:0] lo_wd
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_WB
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [5:0] MUL_LAST = 6'(MUL_LAT);
   localparam logic [5:0] DIV_LAST = 6'd31;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sgn_q, sgn_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic        hi_we_q, hi_we_d;
   logic        lo_we_q, lo_we_d;
   logic [31:0] hi_wd_q, hi_wd_d;
   logic [31:0] lo_wd_q, lo_wd_d;

   logic        accept;
   logic [63:0] mul_a, mul_b, prod;
   logic [32:0] rem_sh, diff;
   logic        qbit;
   logic [31:0] rem_nxt, quo_nxt;
   logic [31:0] quo_fix, rem_fix;

   // Sign-extend to 64 bits so one unsigned multiply serves both MULT and MULTU.
   always_comb begin
      mul_a = {{32{sgn_q & a_q[31]}}, a_q};
      mul_b = {{32{sgn_q & b_q[31]}}, b_q};
      prod  = mul_a * mul_b;
   end

   // One restoring step: the dividend shifts out MSB first while quotient bits shift in.
   always_comb begin
      rem_sh  = {rem_q, dvd_q[31]};
      diff    = rem_sh - {1'b0, dvs_q};
      qbit    = ~diff[32];
      rem_nxt = qbit ? diff[31:0] : rem_sh[31:0];
      quo_nxt = {dvd_q[30:0], qbit};
      quo_fix = qneg_q ? (32'd0 - quo_nxt) : quo_nxt;
      rem_fix = rneg_q ? (32'd0 - rem_nxt) : rem_nxt;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_we_d = 1'b0;
      lo_we_d = 1'b0;
      hi_wd_d = hi_wd_q;
      lo_wd_d = lo_wd_q;
      accept  = start && !flush && (state_q == S_IDLE || state_q == S_WB);

      case (state_q)
         S_MUL: begin
            if (cnt_q == MUL_LAST) begin
               hi_we_d = 1'b1;
               lo_we_d = 1'b1;
               hi_wd_d = prod[63:32];
               lo_wd_d = prod[31:0];
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_DIV: begin
            dvd_d = quo_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == DIV_LAST) begin
               hi_we_d = 1'b1;
               lo_we_d = 1'b1;
               hi_wd_d = dz_q ? a_q : rem_fix;
               lo_wd_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
               state_d = S_WB;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         case (op)
            OP_MULT, OP_MULTU: begin
               a_d     = a;
               b_d     = b;
               sgn_d   = ~op[0];
               cnt_d   = 6'd1;
               state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
               sgn_d   = ~op[0];
               a_d     = a;
               b_d     = b;
               dvd_d   = (~op[0] && a[31]) ? (32'd0 - a) : a;
               dvs_d   = (~op[0] && b[31]) ? (32'd0 - b) : b;
               rem_d   = 32'd0;
               qneg_d  = ~op[0] & (a[31] ^ b[31]);
               rneg_d  = ~op[0] & a[31];
               dz_d    = (b == 32'd0);
               cnt_d   = 6'd0;
               state_d = S_DIV;
            end
            OP_MTHI: begin
               hi_we_d = 1'b1;
               hi_wd_d = a;
               state_d = S_WB;
            end
            OP_MTLO: begin
               lo_we_d = 1'b1;
               lo_wd_d = a;
               state_d = S_WB;
            end
            default: ;
         endcase
      end

      if (flush) begin
         state_d = S_IDLE;
         hi_we_d = 1'b0;
         lo_we_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         rem_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_we_q <= 1'b0;
         lo_we_q <= 1'b0;
         hi_wd_q <= 32'd0;
         lo_wd_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_we_q <= hi_we_d;
         lo_we_q <= lo_we_d;
         hi_wd_q <= hi_wd_d;
         lo_wd_q <= lo_wd_d;
      end
   end

   // A flush or reset landing on the WB cycle must squash that cycle's write.
   always_comb begin
      hi_we = hi_we_q & ~(flush | rst);
      lo_we = lo_we_q & ~(flush | rst);
      done  = hi_we | lo_we;
      hi_wd = hi_wd_q;
      lo_wd = lo_wd_q;
      busy  = (state_q == S_MUL) || (state_q == S_DIV) ||
              (start && !op[2] && (state_q == S_IDLE || state_q == S_WB));
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: multiply, divide corner cases,
// moves, back-to-back issue, flush and reset behaviour.
module tb_mdu_ctrl;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_BAD   = 3'b110;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wd;
   logic [31:0] lo_wd;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;
   logic sawStrobe;

   mdu_ctrl #(.MUL_LAT(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .hi_wd (hi_wd),
      .lo_wd (lo_wd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; operands are scrambled so the DUT must rely on its latched copies.
   task automatic nextCycle();
      @(posedge clk);
      #2;
      start = 1'b0;
      flush = 1'b0;
      a     = $urandom;
      b     = $urandom;
      #1;
      sawStrobe = sawStrobe | done;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) nextCycle();
   endtask

   task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] av,
                                input logic [31:0] bv, input logic fl);
      start = s;
      op    = o;
      a     = av;
      b     = bv;
      flush = fl;
      #1;
   endtask

   task automatic runDivide(input string tag, input logic [2:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] expHi, input logic [31:0] expLo);
      nextCycle();
      applyStimulus(1'b1, o, av, bv, 1'b0);
      checkOutput({tag, " busy c0"}, busy, 1);
      waitCycles(32);
      checkOutput({tag, " busy c32"}, busy, 1);
      checkOutput({tag, " done c32"}, done, 0);
      nextCycle();
      checkOutput({tag, " busy c33"}, busy, 0);
      checkOutput({tag, " we c33"}, {hi_we, lo_we}, 2'b11);
      checkOutput({tag, " hi c33"}, hi_wd, expHi);
      checkOutput({tag, " lo c33"}, lo_wd, expLo);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; flush = 1'b0;
      sawStrobe = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset we", {hi_we, lo_we}, 2'b00);
      checkOutput("reset hi_wd", hi_wd, 32'h0);
      checkOutput("reset lo_wd", lo_wd, 32'h0);

      // MULT -2 * 3
      nextCycle();
      applyStimulus(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      checkOutput("mult busy c0", busy, 1);
      nextCycle();
      checkOutput("mult busy c1", busy, 1);
      checkOutput("mult done c1", done, 0);
      nextCycle();
      checkOutput("mult busy c2", busy, 1);
      checkOutput("mult done c2", done, 0);
      nextCycle();
      checkOutput("mult busy c3", busy, 0);
      checkOutput("mult we c3", {hi_we, lo_we, done}, 3'b111);
      checkOutput("mult hi", hi_wd, 32'hFFFF_FFFF);
      checkOutput("mult lo", lo_wd, 32'hFFFF_FFFA);
      nextCycle();
      checkOutput("mult done c4", done, 0);

      // MULTU 0xFFFFFFFE * 3
      applyStimulus(1'b1, OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
      waitCycles(3);
      checkOutput("multu we", {hi_we, lo_we}, 2'b11);
      checkOutput("multu hi", hi_wd, 32'h0000_0002);
      checkOutput("multu lo", lo_wd, 32'hFFFF_FFFA);

      runDivide("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runDivide("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      runDivide("divu by0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
      runDivide("div by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      runDivide("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      runDivide("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

      // MTLO then MULT in the WB cycle, then MTHI in the MULT's WB cycle
      nextCycle();
      applyStimulus(1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
      checkOutput("mtlo busy c0", busy, 0);
      nextCycle();
      checkOutput("mtlo busy c1", busy, 0);
      checkOutput("mtlo we c1", {hi_we, lo_we}, 2'b01);
      checkOutput("mtlo lo", lo_wd, 32'hDEAD_BEEF);
      applyStimulus(1'b1, OP_MULT, 32'd5, 32'd7, 1'b0);
      checkOutput("b2b mult busy", busy, 1);
      waitCycles(3);
      checkOutput("b2b mult we c4", {hi_we, lo_we}, 2'b11);
      checkOutput("b2b mult lo", lo_wd, 32'd35);
      checkOutput("b2b mult hi", hi_wd, 32'd0);
      applyStimulus(1'b1, OP_MTHI, 32'h0000_0011, 32'd0, 1'b0);
      checkOutput("mthi busy", busy, 0);
      nextCycle();
      checkOutput("mthi we", {hi_we, lo_we}, 2'b10);
      checkOutput("mthi hi", hi_wd, 32'h0000_0011);

      // Illegal op does nothing
      nextCycle();
      applyStimulus(1'b1, OP_BAD, 32'h1, 32'h1, 1'b0);
      checkOutput("bad op busy c0", busy, 0);
      nextCycle();
      checkOutput("bad op done c1", done, 0);
      checkOutput("bad op busy c1", busy, 0);

      // DIV with an ignored start at cycle 5 and a flush at cycle 10
      nextCycle();
      applyStimulus(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0);
      sawStrobe = 1'b0;
      waitCycles(5);
      applyStimulus(1'b1, OP_MULT, 32'd2, 32'd2, 1'b0);
      checkOutput("flush busy c5", busy, 1);
      waitCycles(5);
      applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1);
      checkOutput("flush done c10", done, 0);
      checkOutput("flush no strobe c1-10", sawStrobe, 0);
      nextCycle();
      checkOutput("flush busy c11", busy, 0);
      applyStimulus(1'b1, OP_MTLO, 32'h0000_CAFE, 32'd0, 1'b0);
      nextCycle();
      checkOutput("post-flush mtlo we", {hi_we, lo_we}, 2'b01);
      checkOutput("post-flush mtlo lo", lo_wd, 32'h0000_CAFE);
      sawStrobe = 1'b0;
      waitCycles(25);
      checkOutput("flushed div never writes", sawStrobe, 0);

      // Flush landing on the WB cycle suppresses the write
      applyStimulus(1'b1, OP_MULT, 32'd3, 32'd3, 1'b0);
      waitCycles(3);
      applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1);
      checkOutput("wb flush we", {hi_we, lo_we}, 2'b00);
      checkOutput("wb flush done", done, 0);
      nextCycle();
      checkOutput("wb flush busy after", busy, 0);

      // Reset in the middle of a multiply
      applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b0);
      nextCycle();
      rst = 1'b1;
      #1;
      nextCycle();
      rst = 1'b0;
      #1;
      sawStrobe = 1'b0;
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst hi_wd", hi_wd, 32'h0);
      checkOutput("rst lo_wd", lo_wd, 32'h0);
      waitCycles(3);
      checkOutput("rst no late write", sawStrobe, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
